// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with ALU decoder
// and the external memory handshake for fetch, lw and sw.
module mc_controller #(
    parameter bit USE_MEMREADY = 1'b0,
    parameter bit HAS_BNE      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
        RTYPEWB, BEQEX, BNEEX, ADDIEX, ADDIWB, JEX
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state;
    state_t     dec_next;
    logic       rdy;
    logic       op_ok;
    logic       fn_ok;
    logic [2:0] fn_ctl;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       irw;
    logic       rw;
    logic       mw;

    assign rdy = USE_MEMREADY ? memready : 1'b1;

    always_comb begin
        op_ok    = 1'b1;
        dec_next = FETCH;
        case (op)
            OP_LW, OP_SW: dec_next = MEMADR;
            OP_R:         dec_next = RTYPEEX;
            OP_BEQ:       dec_next = BEQEX;
            OP_BNE: begin
                dec_next = HAS_BNE ? BNEEX : FETCH;
                op_ok    = HAS_BNE;
            end
            OP_ADDI:      dec_next = ADDIEX;
            OP_J:         dec_next = JEX;
            default:      op_ok = 1'b0;
        endcase
    end

    always_comb begin
        fn_ok  = 1'b1;
        fn_ctl = 3'b010;
        case (funct)
            6'b100000: fn_ctl = 3'b010;
            6'b100010: fn_ctl = 3'b110;
            6'b100100: fn_ctl = 3'b000;
            6'b100101: fn_ctl = 3'b001;
            6'b101010: fn_ctl = 3'b111;
            default:   fn_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (rdy) state <= DECODE;
                DECODE:  state <= op_ok ? dec_next : FETCH;
                MEMADR:  state <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   if (rdy) state <= MEMWB;
                MEMWB:   state <= FETCH;
                MEMWR:   if (rdy) state <= FETCH;
                RTYPEEX: state <= fn_ok ? RTYPEWB : FETCH;
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        irw        = 1'b0;
        rw         = 1'b0;
        mw         = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                alusrcb = 2'b01;
                irw     = rdy;
                pcwrite = rdy;
            end
            DECODE: begin
                alusrcb = 2'b11;
                illegal = ~op_ok;
            end
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                rw       = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                mw   = 1'b1;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = fn_ctl;
                illegal    = ~fn_ok;
            end
            RTYPEWB: begin
                regdst = 1'b1;
                rw     = 1'b1;
            end
            BEQEX, BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = (state == BEQEX);
                branchne   = (state == BNEEX);
            end
            ADDIWB: rw = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Write-type strobes are gated by reset so an abort drops them at once.
    assign pcen     = reset & (pcwrite | (branch & zero) | (branchne & ~zero));
    assign irwrite  = reset & irw;
    assign regwrite = reset & rw;
    assign memwrite = reset & mw;

endmodule
